// File: rtl/z80_dma_busmaster_if.sv
// System-bus bundle between the DMA block-copy engine, chip_z80 (bus handshake) and the RAM.
// Signal names follow the SoC bus naming; the leading underscore marks active-low lines.
interface z80_dma_busmaster_if;
   logic        _busrq;
   logic        _busak;
   logic        bus_oe;
   logic [15:0] ab_o;
   logic [7:0]  db_o;
   logic [7:0]  db_i;
   logic        _mreq_o;
   logic        _rd_o;
   logic        _wr_o;

   modport master (
      output _busrq, bus_oe, ab_o, db_o, _mreq_o, _rd_o, _wr_o,
      input  _busak, db_i
   );

   modport slave (
      input  _busrq, bus_oe, ab_o, db_o, _mreq_o, _rd_o, _wr_o,
      output _busak, db_i
   );
endinterface

// File: rtl/z80_dma_busmaster.sv
// Block-copy DMA: borrows the Z80 bus via _busrq/_busak, copies len bytes src->dst, returns the bus.
// state | meaning
// IDLE  | waiting for start
// REQ   | _busrq low, waiting for synchronised _busak low
// RD    | memory read of src, ACC_CYCLES long
// WR    | memory write to dst, ACC_CYCLES long (_wr_o held off on the first cycle)
// REL   | _busrq high, waiting for synchronised _busak high
// DONE  | one-cycle done pulse
// ABORT | one-cycle error pulse after a _busak timeout
module z80_dma_busmaster #(
   parameter int ACC_CYCLES    = 4,
   parameter int BUSAK_TIMEOUT = 1023
) (
   input  logic                        eclk,
   input  logic                        ereset,
   input  logic                        start,
   input  logic [15:0]                 src_addr,
   input  logic [15:0]                 dst_addr,
   input  logic [15:0]                 len,
   output logic                        busy,
   output logic                        done,
   output logic                        error,
   z80_dma_busmaster_if.master         bus
);

   localparam int TW = $clog2((BUSAK_TIMEOUT > ACC_CYCLES) ? BUSAK_TIMEOUT : ACC_CYCLES);
   localparam logic [TW-1:0] ACC_LOAD = TW'(ACC_CYCLES - 1);
   localparam logic [TW-1:0] TO_LOAD  = TW'(BUSAK_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_RD, S_WR, S_REL, S_DONE, S_ABORT
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic [15:0]   src_q, src_d;
   logic [15:0]   dst_q, dst_d;
   logic [15:0]   rem_q, rem_d;
   logic [7:0]    data_q, data_d;
   logic          busak_q;

   always_ff @(posedge eclk) begin
      if (ereset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         data_q  <= '0;
         busak_q <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         data_q  <= data_d;
         busak_q <= bus._busak;
      end
   end

   // cnt_q is a down-counter; each state loads it on entry and watches for zero
   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q != '0) ? cnt_q - TW'(1) : '0;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      data_d  = data_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               src_d = src_addr;
               dst_d = dst_addr;
               rem_d = len;
               if (len == 16'd0) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_REQ;
                  cnt_d   = TO_LOAD;
               end
            end
         end
         S_REQ: begin
            if (!bus._busak && !busak_q) begin
               state_d = S_RD;
               cnt_d   = ACC_LOAD;
            end else if (cnt_q == '0) begin
               state_d = S_ABORT;
            end
         end
         S_RD: begin
            if (cnt_q == '0) begin
               data_d  = bus.db_i;
               state_d = S_WR;
               cnt_d   = ACC_LOAD;
            end
         end
         S_WR: begin
            if (cnt_q == '0) begin
               src_d = src_q + 16'd1;
               dst_d = dst_q + 16'd1;
               rem_d = rem_q - 16'd1;
               if (rem_q == 16'd1) begin
                  state_d = S_REL;
                  cnt_d   = TO_LOAD;
               end else begin
                  state_d = S_RD;
                  cnt_d   = ACC_LOAD;
               end
            end
         end
         S_REL: begin
            if (bus._busak && busak_q) begin
               state_d = S_DONE;
            end else if (cnt_q == '0) begin
               state_d = S_ABORT;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ABORT: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // All outputs decode from registered state, so a reset shows on the very next cycle
   assign busy        = (state_q == S_REQ) || (state_q == S_RD) || (state_q == S_WR) || (state_q == S_REL);
   assign done        = (state_q == S_DONE);
   assign error       = (state_q == S_ABORT);
   assign bus._busrq  = !((state_q == S_REQ) || (state_q == S_RD) || (state_q == S_WR));
   assign bus.bus_oe  = (state_q == S_RD) || (state_q == S_WR);
   assign bus.ab_o    = (state_q == S_RD) ? src_q : ((state_q == S_WR) ? dst_q : 16'h0000);
   assign bus.db_o    = (state_q == S_WR) ? data_q : 8'h00;
   assign bus._mreq_o = !((state_q == S_RD) || (state_q == S_WR));
   assign bus._rd_o   = !(state_q == S_RD);
   assign bus._wr_o   = !((state_q == S_WR) && (cnt_q != ACC_LOAD));

endmodule
